// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the clock divider bank.
// Latency: n/a (pure functions and types).
// Backpressure: n/a.
//
// Contents:
//   MIN_DIVISION    smallest divisor a channel will ever run with
//   clamp_t         {value, clamped} result of a divisor clamp
//   clamp_division  raises divisors below MIN_DIVISION and flags it
//   half_period     high-phase length for a divisor: ceil(div/2)
package clock_divider_pkg;

   localparam int MIN_DIVISION = 2;

   typedef struct packed {
      logic [31:0] value;
      logic        clamped;
   } clamp_t;

   function automatic clamp_t clamp_division(input logic [31:0] division);
      clamp_t res;
      res.clamped = (division < 32'(MIN_DIVISION));
      res.value   = res.clamped ? 32'(MIN_DIVISION) : division;
      return res;
   endfunction

   // 32-bit arithmetic so a full-scale divisor does not overflow the +1.
   function automatic logic [31:0] half_period(input logic [31:0] division);
      return (division + 32'd1) >> 1;
   endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: cnt/div pair, apply-on-wrap divisor load, registered output.
// Latency: output_clock follows cnt by one edge; a load is taken on wrap, align or while disabled.
// Backpressure: load_taken tells the owner of the pending slot when the divisor was consumed.
//
// Ports:
//   input_clock, reset         clock, async active-high reset
//   enable, align              run enable, phase restart (forces cnt to 0)
//   load_valid, load_division  pending divisor addressed to this channel
//   load_taken                 combinational: divisor loads on this edge
//   output_clock               divided clock, high while cnt < ceil(div/2)
//   strobe                     (CLOCK_DIVIDER_BANK_STROBE_EN) one-cycle pulse on each output rise
module clock_divider_channel
   import clock_divider_pkg::*;
#(
   parameter int                   DIV_WIDTH      = 8,
   parameter logic [DIV_WIDTH-1:0] RESET_DIVISION = 2
) (
   input  logic                 input_clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 align,
   input  logic                 load_valid,
   input  logic [DIV_WIDTH-1:0] load_division,
   output logic                 load_taken,
   output logic                 output_clock
`ifdef CLOCK_DIVIDER_BANK_STROBE_EN
   ,
   output logic                 strobe
`endif
);

   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] div;
   logic                 wrap;
   logic                 high_next;

   assign wrap      = (cnt == div - DIV_WIDTH'(1));
   assign high_next = (32'(cnt) < half_period(32'(div)));

   // A disabled channel has no phase to protect, so it takes a divisor at once.
   assign load_taken = load_valid && (!enable || align || wrap);

   always_ff @(posedge input_clock or posedge reset) begin
      if (reset) begin
         cnt          <= '0;
         div          <= RESET_DIVISION;
         output_clock <= 1'b0;
      end else begin
         if (load_taken) begin
            div <= load_division;
         end
         if (!enable || align) begin
            // Output is pulled low here so the restarted phase shows as a
            // clean rising edge on the following cycle.
            cnt          <= '0;
            output_clock <= 1'b0;
         end else begin
            output_clock <= high_next;
            cnt          <= wrap ? '0 : cnt + DIV_WIDTH'(1);
         end
      end
   end

`ifdef CLOCK_DIVIDER_BANK_STROBE_EN
   // Strobe goes high in the same cycle output_clock goes high.
   always_ff @(posedge input_clock or posedge reset) begin
      if (reset) begin
         strobe <= 1'b0;
      end else begin
         strobe <= enable && !align && high_next && !output_clock;
      end
   end
`else
   // No strobe: output_clock is the only product of this channel.
`endif

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel runtime-programmable clock divider with a single pending config slot.
// Latency: config accepted in 1 edge, applied at the target channel's next wrap (<= div cycles).
// Backpressure: config_ready low while a divisor is pending; out-of-range requests never block.
//
// Ports:
//   input_clock, reset            clock, async active-high reset
//   enable[CHANNELS]              per-channel run enable
//   align                         restarts phase of all enabled channels
//   config_valid/config_ready     divisor update handshake
//   config_channel/division       target channel and new divisor
//   config_error                  one-cycle pulse: clamped divisor or bad channel
//   output_clock[CHANNELS]        divided clocks, registered
//   strobe[CHANNELS]              present only with CLOCK_DIVIDER_BANK_STROBE_EN defined
module clock_divider_bank
   import clock_divider_pkg::*;
#(
   parameter int  CHANNELS         = 4,
   parameter int  DIV_WIDTH        = 8,
   parameter int  DEFAULT_DIVISION = 2,
   localparam int CH_W             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 input_clock,
   input  logic                 reset,
   input  logic [CHANNELS-1:0]  enable,
   input  logic                 align,
   input  logic                 config_valid,
   output logic                 config_ready,
   input  logic [CH_W-1:0]      config_channel,
   input  logic [DIV_WIDTH-1:0] config_division,
   output logic                 config_error,
   output logic [CHANNELS-1:0]  output_clock
`ifdef CLOCK_DIVIDER_BANK_STROBE_EN
   ,
   output logic [CHANNELS-1:0]  strobe
`endif
);

   localparam logic [DIV_WIDTH-1:0] RESET_DIVISION =
      DIV_WIDTH'((DEFAULT_DIVISION < MIN_DIVISION) ? MIN_DIVISION : DEFAULT_DIVISION);

   logic                 pend_vld;
   logic [CH_W-1:0]      pend_ch;
   logic [DIV_WIDTH-1:0] pend_div;
   logic [CHANNELS-1:0]  taken;
   logic                 accept;
   logic                 out_of_range;
   clamp_t               clamp_res;

   assign config_ready = !pend_vld;
   assign accept       = config_valid && config_ready;
   assign out_of_range = (32'(config_channel) >= 32'(CHANNELS));
   assign clamp_res    = clamp_division(32'(config_division));

   always_ff @(posedge input_clock or posedge reset) begin
      if (reset) begin
         pend_vld     <= 1'b0;
         pend_ch      <= '0;
         pend_div     <= RESET_DIVISION;
         config_error <= 1'b0;
      end else begin
         config_error <= accept && (out_of_range || clamp_res.clamped);
         // Acceptance needs an empty slot, so it never collides with a take.
         if (accept && !out_of_range) begin
            pend_vld <= 1'b1;
            pend_ch  <= config_channel;
            pend_div <= DIV_WIDTH'(clamp_res.value);
         end else if (|taken) begin
            pend_vld <= 1'b0;
         end
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic hit;
      assign hit = pend_vld && (pend_ch == CH_W'(i));

      clock_divider_channel #(
         .DIV_WIDTH      (DIV_WIDTH),
         .RESET_DIVISION (RESET_DIVISION)
      ) u_channel (
         .input_clock   (input_clock),
         .reset         (reset),
         .enable        (enable[i]),
         .align         (align),
         .load_valid    (hit),
         .load_division (pend_div),
         .load_taken    (taken[i]),
         .output_clock  (output_clock[i])
`ifdef CLOCK_DIVIDER_BANK_STROBE_EN
         ,
         .strobe        (strobe[i])
`endif
      );
   end

endmodule

// File: tb/tb_clock_divider_bank.sv
module tb_clock_divider_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] enable;
   logic       align;
   logic       cfg_valid;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_div;
   wire        cfg_ready;
   wire        cfg_err;
   wire  [3:0] out_clk;

   // Three-channel instance: the only way to present an out-of-range index.
   logic [2:0] en3;
   logic       v3;
   logic [1:0] ch3;
   logic [7:0] d3;
   wire        r3;
   wire        e3;
   wire  [2:0] o3;

`ifdef CLOCK_DIVIDER_BANK_STROBE_EN
   wire  [3:0] stb;
   wire  [2:0] stb3;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   clock_divider_bank #(.CHANNELS(4), .DIV_WIDTH(8), .DEFAULT_DIVISION(2)) dut (
      .input_clock     (clk),
      .reset           (rst),
      .enable          (enable),
      .align           (align),
      .config_valid    (cfg_valid),
      .config_ready    (cfg_ready),
      .config_channel  (cfg_ch),
      .config_division (cfg_div),
      .config_error    (cfg_err),
      .output_clock    (out_clk)
`ifdef CLOCK_DIVIDER_BANK_STROBE_EN
      ,
      .strobe          (stb)
`endif
   );

   clock_divider_bank #(.CHANNELS(3), .DIV_WIDTH(8), .DEFAULT_DIVISION(2)) dut3 (
      .input_clock     (clk),
      .reset           (rst),
      .enable          (en3),
      .align           (1'b0),
      .config_valid    (v3),
      .config_ready    (r3),
      .config_channel  (ch3),
      .config_division (d3),
      .config_error    (e3),
      .output_clock    (o3)
`ifdef CLOCK_DIVIDER_BANK_STROBE_EN
      ,
      .strobe          (stb3)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] s0, s1;
      logic [7:0] s2;
      logic [3:0] s4;
      logic [3:0] hist [0:20];
      int exp_per [4];
      int exp_hi  [4];
      exp_per = '{2, 3, 4, 5};
      exp_hi  = '{1, 2, 2, 3};

      rst = 1'b1; enable = 4'hF; align = 1'b0;
      cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
      en3 = 3'h7; v3 = 1'b0; ch3 = 2'd0; d3 = 8'd0;

      // Reset state.
      #2;
      check_val("rst_out", out_clk, 4'h0);
      check_val("rst_ready", cfg_ready, 1'b1);
      check_val("rst_err", cfg_err, 1'b0);
      check_val("rst_out3", o3, 3'h0);
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst = 1'b0;

      // Default divisor 2: first edge high, then toggling.
      tick; check_val("e1_out", out_clk, 4'hF); check_val("e1_out3", o3, 3'h7);
`ifdef CLOCK_DIVIDER_BANK_STROBE_EN
      check_val("e1_stb", stb, 4'hF);
`endif
      tick; check_val("e2_out", out_clk, 4'h0);
`ifdef CLOCK_DIVIDER_BANK_STROBE_EN
      check_val("e2_stb", stb, 4'h0);
`endif
      tick; check_val("e3_out", out_clk, 4'hF);
      tick; check_val("e4_out", out_clk, 4'h0); check_val("e4_ready", cfg_ready, 1'b1);

      // ch1 <- 3: accepted E5, applied at ch1 wrap on E6.
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
      tick; cfg_valid = 1'b0;
      check_val("c1_ready_lo", cfg_ready, 1'b0);
      check_val("c1_out", out_clk, 4'hF);
      check_val("c1_err", cfg_err, 1'b0);
      tick;
      check_val("c1_ready_hi", cfg_ready, 1'b1);
      check_val("c1_out_wrap", out_clk, 4'h0);
      s0 = '0; s1 = '0;
      for (int k = 0; k < 6; k++) begin
         tick;
         s0 = {s0[4:0], out_clk[0]};
         s1 = {s1[4:0], out_clk[1]};
      end
      check_val("c1_ch1_wave", s1, 6'b110110);
      check_val("c1_ch0_wave", s0, 6'b101010);

      // ch2 <- 4.
      cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd4;
      tick; cfg_valid = 1'b0;
      check_val("c2_ready_lo", cfg_ready, 1'b0);
      tick;
      check_val("c2_ready_hi", cfg_ready, 1'b1);
      s2 = '0;
      for (int k = 0; k < 8; k++) begin
         tick;
         s2 = {s2[6:0], out_clk[2]};
      end
      check_val("c2_ch2_wave", s2, 8'b11001100);

      // ch3 <- 5.
      cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5;
      tick; cfg_valid = 1'b0;
      check_val("c3_ready_lo", cfg_ready, 1'b0);
      tick;
      check_val("c3_ready_hi", cfg_ready, 1'b1);

      // Period and high time per channel from rising edge to rising edge.
      hist[0] = out_clk;
      for (int k = 1; k <= 20; k++) begin
         tick;
         hist[k] = out_clk;
      end
      for (int c = 0; c < 4; c++) begin
         int r1, r2, hi;
         r1 = -1; r2 = -1; hi = 0;
         for (int k = 1; k <= 20; k++) begin
            if (hist[k][c] && !hist[k-1][c]) begin
               if (r1 < 0) r1 = k;
               else if (r2 < 0) r2 = k;
            end
         end
         if (r1 >= 0 && r2 > r1) begin
            for (int k = r1; k < r2; k++) hi += int'(hist[k][c]);
         end
         check_val($sformatf("period_ch%0d", c), (r1 >= 0 && r2 > r1) ? r2 - r1 : 0, exp_per[c]);
         check_val($sformatf("high_ch%0d", c), hi, exp_hi[c]);
      end

      // D=0 to ch0 is clamped to 2; index 3 on the 3-channel instance is discarded.
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
      v3 = 1'b1; ch3 = 2'd3; d3 = 8'd4;
      tick; cfg_valid = 1'b0; v3 = 1'b0;
      check_val("clamp_err_hi", cfg_err, 1'b1);
      check_val("clamp_ready_lo", cfg_ready, 1'b0);
      check_val("oob_err_hi", e3, 1'b1);
      check_val("oob_ready_hi", r3, 1'b1);
      check_val("oob_out3_a", o3, 3'h7);
      tick;
      check_val("clamp_err_lo", cfg_err, 1'b0);
      check_val("clamp_ready_hi", cfg_ready, 1'b1);
      check_val("oob_err_lo", e3, 1'b0);
      check_val("oob_out3_b", o3, 3'h0);
      s4 = '0;
      for (int k = 0; k < 4; k++) begin
         tick;
         s4 = {s4[2:0], out_clk[0]};
      end
      check_val("clamp_ch0_wave", s4, 4'b1010);
      check_val("oob_out3_c", o3, 3'h0);

      // Align together with a request on ch3 (same divisor, held to next wrap).
      align = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5;
      tick; align = 1'b0; cfg_valid = 1'b0;
      check_val("al_out0", out_clk, 4'h0);
      check_val("al_ready0", cfg_ready, 1'b0);
`ifdef CLOCK_DIVIDER_BANK_STROBE_EN
      check_val("al_stb0", stb, 4'h0);
`endif
      tick; check_val("al_out1", out_clk, 4'hF); check_val("al_ready1", cfg_ready, 1'b0);
`ifdef CLOCK_DIVIDER_BANK_STROBE_EN
      check_val("al_stb1", stb, 4'hF);
`endif
      tick; check_val("al_out2", out_clk, 4'b1110);
      tick; check_val("al_out3", out_clk, 4'b1001);
      tick; check_val("al_out4", out_clk, 4'b0010); check_val("al_ready4", cfg_ready, 1'b0);
      tick; check_val("al_out5", out_clk, 4'b0111); check_val("al_ready5", cfg_ready, 1'b1);

      // Disable ch2 mid-high with an update for it; update lands while disabled.
      enable = 4'b1011; cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd6;
      tick; cfg_valid = 1'b0;
      check_val("dis_out2", out_clk[2], 1'b0);
      check_val("dis_ready_lo", cfg_ready, 1'b0);
      tick;
      check_val("dis_ready_hi", cfg_ready, 1'b1);
      check_val("dis_out2_b", out_clk[2], 1'b0);
      enable = 4'hF;
      s0 = '0;
      for (int k = 0; k < 6; k++) begin
         tick;
         s0 = {s0[4:0], out_clk[2]};
      end
      check_val("reen_ch2_wave", s0, 6'b111000);

      // Reset with an update pending on ch3.
      cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd9;
      tick; cfg_valid = 1'b0;
      check_val("rp_ready_lo", cfg_ready, 1'b0);
      #3 rst = 1'b1;
      #1;
      check_val("rp_out_async", out_clk, 4'h0);
      check_val("rp_err", cfg_err, 1'b0);
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      check_val("rp_ready_rel", cfg_ready, 1'b1);
      tick; check_val("rp_out_e1", out_clk, 4'hF);
      s4 = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         tick;
         s4 = {s4[2:0], out_clk[3]};
      end
      check_val("rp_ch3_wave", s4, 4'b1010);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
